// File: rtl/hazard_pkg.sv
// Shared types and constants for the RV32 hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_md_fsm.sv
// Multi-cycle execute hold: keeps a MUL/DIV op in E for MD_LAT cycles.
// Combinational outputs from state + inputs; freeze halts all state progress.
module hazard_md_fsm
  import hazard_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic md_start,
  input  logic freeze,
  output logic md_hold,
  output logic md_busy,
  output logic md_done
);

  localparam int CW = $clog2(MD_LAT + 1);

  md_state_e       state;
  logic [CW-1:0]   cnt;

  // Single-cycle ops complete in place, so the FSM only arms for MD_LAT >= 2.
  logic start_ok;
  assign start_ok = md_start && (MD_LAT >= 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else if (!freeze) begin
      case (state)
        MD_IDLE: begin
          if (start_ok) begin
            state <= MD_BUSY;
            cnt   <= CW'(MD_LAT - 1);
          end
        end
        MD_BUSY: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  // A frozen op cannot leave E, so the release is deferred until the freeze lifts.
  assign md_busy = (state == MD_BUSY);
  assign md_hold = md_busy ? (cnt > CW'(1)) : start_ok;
  assign md_done = (md_busy && (cnt == CW'(1)) && !freeze) ||
                   ((MD_LAT == 1) && md_start);

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding selects, stalls, flushes.
// Priority: memory-wait freeze > multi-cycle hold > branch redirect > load-use/RAW stall.
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter int MD_LAT = 4,
  parameter bit FWD_EN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rs1_d_i,
  input  logic [REG_AW-1:0] rs2_d_i,
  input  logic [REG_AW-1:0] rs1_e_i,
  input  logic [REG_AW-1:0] rs2_e_i,
  input  logic [REG_AW-1:0] rd_e_i,
  input  logic [REG_AW-1:0] rd_m_i,
  input  logic [REG_AW-1:0] rd_w_i,
  input  logic              reg_write_e_i,
  input  logic              reg_write_m_i,
  input  logic              reg_write_w_i,
  input  logic              result_src_e_i,
  input  logic              md_start_e_i,
  input  logic              pc_src_e_i,
  input  logic              dmem_req_m_i,
  input  logic              dmem_ack_m_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              stall_f_o,
  output logic              stall_d_o,
  output logic              stall_e_o,
  output logic              stall_m_o,
  output logic              stall_w_o,
  output logic              flush_d_o,
  output logic              flush_e_o,
  output logic              flush_m_o,
  output logic              md_busy_o,
  output logic              md_done_o
);

  localparam logic [REG_AW-1:0] ZERO = REG_AW'(REG_ZERO);

  function automatic fwd_sel_e fwd_pick(input logic [REG_AW-1:0] rs,
                                        input logic [REG_AW-1:0] rd_m,
                                        input logic              we_m,
                                        input logic [REG_AW-1:0] rd_w,
                                        input logic              we_w);
    if (!FWD_EN || rs == ZERO) return FWD_RF;
    if (we_m && rs == rd_m)    return FWD_M;
    if (we_w && rs == rd_w)    return FWD_W;
    return FWD_RF;
  endfunction

  fwd_sel_e fwd_a, fwd_b;
  assign fwd_a       = fwd_pick(rs1_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
  assign fwd_b       = fwd_pick(rs2_e_i, rd_m_i, reg_write_m_i, rd_w_i, reg_write_w_i);
  assign forward_a_o = fwd_a;
  assign forward_b_o = fwd_b;

  logic mem_wait, md_hold;
  assign mem_wait = dmem_req_m_i && !dmem_ack_m_i;

  hazard_md_fsm #(.MD_LAT(MD_LAT)) u_md_fsm (
    .clk      (clk_i),
    .rst      (rst_i),
    .md_start (md_start_e_i),
    .freeze   (mem_wait),
    .md_hold  (md_hold),
    .md_busy  (md_busy_o),
    .md_done  (md_done_o)
  );

  logic load_use, raw_e, raw_m, d_hazard;
  assign load_use = result_src_e_i && (rd_e_i != ZERO) &&
                    ((rs1_d_i == rd_e_i) || (rs2_d_i == rd_e_i));
  // Without bypass every in-flight producer in E/M blocks D; W writes first so it is safe.
  assign raw_e = reg_write_e_i && (((rs1_d_i != ZERO) && (rs1_d_i == rd_e_i)) ||
                                   ((rs2_d_i != ZERO) && (rs2_d_i == rd_e_i)));
  assign raw_m = reg_write_m_i && (((rs1_d_i != ZERO) && (rs1_d_i == rd_m_i)) ||
                                   ((rs2_d_i != ZERO) && (rs2_d_i == rd_m_i)));
  assign d_hazard = load_use || (!FWD_EN && (raw_e || raw_m));

  always_comb begin
    stall_f_o = 1'b0;
    stall_d_o = 1'b0;
    stall_e_o = 1'b0;
    stall_m_o = 1'b0;
    stall_w_o = 1'b0;
    flush_d_o = 1'b0;
    flush_e_o = 1'b0;
    flush_m_o = 1'b0;
    if (mem_wait) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      stall_m_o = 1'b1;
      stall_w_o = 1'b1;
    end else if (md_hold) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      stall_e_o = 1'b1;
      flush_m_o = 1'b1;
    end else if (pc_src_e_i) begin
      // Redirect must load into F, so it wins over any D-side stall.
      flush_d_o = 1'b1;
      flush_e_o = 1'b1;
    end else if (d_hazard) begin
      stall_f_o = 1'b1;
      stall_d_o = 1'b1;
      flush_e_o = 1'b1;
    end
  end

endmodule
